// File: rtl/mem_bus_ctrl.sv
// Memory bus sequencer: latches one CPU request, drives the memory address/data,
// times the ROM/RAM strobes with per-device wait states and returns an ack/err pulse.
module mem_bus_ctrl #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rom_sel,
    input  logic              ram_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rom_rd,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: req is a level sampled only while IDLE (no queueing); ack is a
    // single-cycle completion pulse with err qualifying it; there is no backpressure.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

    state_t     state;
    logic [3:0] cnt;
    logic       we_q;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            rom_rd    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        we_q      <= we;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // The decoder output reflects mem_addr registered on the previous edge.
                    if (ram_sel && !rom_sel) begin
                        cnt    <= RAM_WAIT_C;
                        ram_wr <= we_q;
                        ram_rd <= !we_q;
                        state  <= ACCESS;
                    end else if (rom_sel && !ram_sel && !we_q) begin
                        cnt    <= ROM_WAIT_C;
                        rom_rd <= 1'b1;
                        state  <= ACCESS;
                    end else begin
                        // Illegal target: skip the strobe phase, flag err with the ack.
                        ack   <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) begin
                            rdata <= mem_rdata;
                        end
                        rom_rd <= 1'b0;
                        ram_rd <= 1'b0;
                        ram_wr <= 1'b0;
                        ack    <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios plus randomized accesses
// checked against a transaction-level model of timing, strobes and read data.
module tb_mem_bus_ctrl;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 8;
    localparam int ROM_WAIT = 1;
    localparam int RAM_WAIT = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rom_sel;
    logic              ram_sel;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rom_rd;
    logic              ram_rd;
    logic              ram_wr;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;
    logic [1:0]        dbg_state;

    // Clock / reset
    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rom_sel(rom_sel), .ram_sel(ram_sel), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rom_rd(rom_rd), .ram_rd(ram_rd),
        .ram_wr(ram_wr), .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .dbg_state(dbg_state)
    );

    // Address decoder: ROM at 0x0000-0x17FF, RAM at 0x1800-0x1FFF, overridable.
    bit        force_sel = 1'b0;
    logic [1:0] force_val = 2'b00;
    always_comb begin
        if (force_sel) begin
            {rom_sel, ram_sel} = force_val;
        end else begin
            rom_sel = (mem_addr < 13'h1800);
            ram_sel = (mem_addr >= 13'h1800);
        end
    end

    int passed = 0;
    int total  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] rdata_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference model: 0 illegal, 1 ROM read, 2 RAM read, 3 RAM write
    function automatic int exp_kind(input logic [ADDR_W-1:0] a, input logic w,
                                    input bit fs, input logic [1:0] fv);
        logic [1:0] sel;
        sel = fs ? fv : ((a < 13'h1800) ? 2'b10 : 2'b01);
        if (sel == 2'b01) return w ? 3 : 2;
        if (sel == 2'b10 && !w) return 1;
        return 0;
    endfunction

    // Observations collected by the monitor for one access
    int   ack_cyc, rom_n, rrd_n, rwr_n;
    bit   overlap, busy_bad, multi_ack;
    logic err_v;

    // Watches cycles 1.. after the edge that sampled req, acting as the memory
    task automatic monitor(input logic [DATA_W-1:0] rdv, input bit pulse,
                           input logic [ADDR_W-1:0] pulse_addr);
        ack_cyc = -1; rom_n = 0; rrd_n = 0; rwr_n = 0;
        overlap = 0; busy_bad = 0; multi_ack = 0; err_v = 1'b0;
        mem_rdata = ~rdv;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (pulse && k == 2) begin
                req  = 1'b1;
                addr = pulse_addr;
            end
            if (pulse && k == 3) req = 1'b0;
            if (rom_rd) rom_n++;
            if (ram_rd) rrd_n++;
            if (ram_wr) rwr_n++;
            if (ack) begin
                if (ack_cyc >= 0) multi_ack = 1;
                ack_cyc = k;
                err_v   = err;
            end
            if (ack && (rom_rd || ram_rd || ram_wr)) overlap = 1;
            if (busy !== (ack_cyc < 0 || ack_cyc == k)) busy_bad = 1;
            mem_rdata = (rom_rd || ram_rd) ? rdv : ~rdv;
            if (ack_cyc >= 0 && k == ack_cyc + 1) break;
        end
    endtask

    // Scoreboard: compare the observed access against the model
    task automatic check_access(input string tag, input logic [ADDR_W-1:0] a, input logic w,
                                input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rdv,
                                input bit fs, input logic [1:0] fv);
        int kind, wt;
        kind = exp_kind(a, w, fs, fv);
        wt   = (kind == 1) ? ROM_WAIT : RAM_WAIT;
        if (kind == 1 || kind == 2) rdata_exp = rdv;
        exp_q.push_back(rdata_exp);
        chk({tag, ".ack_cycle"}, ack_cyc, (kind == 0) ? 2 : 3 + wt);
        chk({tag, ".err"}, err_v, (kind == 0) ? 1 : 0);
        chk({tag, ".rom_rd_cycles"}, rom_n, (kind == 1) ? wt + 1 : 0);
        chk({tag, ".ram_rd_cycles"}, rrd_n, (kind == 2) ? wt + 1 : 0);
        chk({tag, ".ram_wr_cycles"}, rwr_n, (kind == 3) ? wt + 1 : 0);
        chk({tag, ".ack_strobe_overlap"}, overlap, 0);
        chk({tag, ".multi_ack"}, multi_ack, 0);
        chk({tag, ".busy_window"}, busy_bad, 0);
        chk({tag, ".rdata"}, rdata, exp_q.pop_front());
        chk({tag, ".mem_addr"}, mem_addr, a);
        chk({tag, ".mem_wdata"}, mem_wdata, d);
        chk({tag, ".state_idle"}, dbg_state, 0);
    endtask

    // Driver: one request pulse, then monitor and score
    task automatic do_access(input string tag, input logic [ADDR_W-1:0] a, input logic w,
                             input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rdv,
                             input bit pulse);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'($urandom_range(0, 1));
        addr  = ADDR_W'($urandom);
        wdata = DATA_W'($urandom);
        monitor(rdv, pulse, a ^ 13'h1555);
        check_access(tag, a, w, d, rdv, force_sel, force_val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_seen;
        logic [ADDR_W-1:0] ra;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.strobes", {rom_rd, ram_rd, ram_wr}, 0);
        chk("reset.ack_err_busy", {ack, err, busy}, 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.rdata", rdata, 0);
        chk("reset.state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b1;

        // T2 RAM write, T3 ROM read, T4 ROM write (illegal)
        do_access("t2_ram_wr", 13'h1805, 1'b1, 8'hA5, 8'h00, 1'b0);
        do_access("t3_rom_rd", 13'h0123, 1'b0, 8'h00, 8'h3C, 1'b0);
        do_access("t4_rom_wr", 13'h0040, 1'b1, 8'h77, 8'h99, 1'b0);
        do_access("pulse_ignored", 13'h1A00, 1'b0, 8'h10, 8'h6E, 1'b1);

        // T5 back-to-back with req held high; address change while busy is ignored
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 13'h1FFF; wdata = 8'h11;
        @(posedge clk);
        #1;
        addr = 13'h1000; wdata = 8'h22;
        monitor(8'h5A, 1'b0, '0);
        check_access("t5_first", 13'h1FFF, 1'b0, 8'h11, 8'h5A, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        req = 1'b0;
        monitor(8'hC3, 1'b0, '0);
        check_access("t5_second", 13'h1000, 1'b0, 8'h22, 8'hC3, 1'b0, 2'b00);

        // T6 decoder reports neither device, then a normal access
        force_sel = 1'b1; force_val = 2'b00;
        do_access("t6_sel00", 13'h1900, 1'b0, 8'h33, 8'h44, 1'b0);
        force_val = 2'b11;
        do_access("t6_sel11", 13'h0900, 1'b0, 8'h35, 8'h46, 1'b0);
        force_sel = 1'b0;
        do_access("t6_after", 13'h1900, 1'b0, 8'h55, 8'h66, 1'b0);

        // Randomized accesses, occasionally with a faulty decoder
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(13'h1800, 13'h1FFF))
                                             : ADDR_W'($urandom_range(0, 13'h17FF));
            force_sel = ($urandom_range(0, 7) == 0);
            force_val = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            do_access($sformatf("rand%0d", i), ra, 1'($urandom_range(0, 1)),
                      DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end
        force_sel = 1'b0;

        // T1 reset in the middle of a ROM read
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 13'h0123; wdata = 8'h00;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t1.rom_rd_before", rom_rd, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t1.strobes_drop", {rom_rd, ram_rd, ram_wr}, 0);
        chk("t1.busy_ack_drop", {busy, ack, err}, 0);
        chk("t1.state", dbg_state, 0);
        chk("t1.mem_addr", mem_addr, 0);
        chk("t1.rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        ack_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack || busy || rom_rd) ack_seen++;
        end
        chk("t1.no_ack_after", ack_seen, 0);
        rdata_exp = '0;
        do_access("t1_after", 13'h0200, 1'b0, 8'h00, 8'h81, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
